// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// It receives a byte stream made of a 16-bit little-endian word count and
// then count x 4 payload bytes. Each payload word is assembled little-endian
// and written to instruction memory at consecutive word addresses. The CPU is
// stalled while a load session is running.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN. When it is defined, the
// stream carries one trailing byte that must equal the mod-256 sum of the
// header and payload bytes; a mismatch sets the sticky error flag.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  output logic              cpu_stall,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LOAD,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] widx;
  logic [15:0] widx_nxt;
  logic [15:0] count;
  logic [23:0] word_lo;
  logic        rx_fire;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign rx_fire   = rx_valid & rx_ready;
  // Word index is kept at the full count width so the end-of-load compare
  // works even when ADDR_W is narrower; only the address output truncates.
  assign widx_nxt  = widx + 16'd1;
  assign cpu_stall = (state != IDLE);

  // Byte acceptance is a pure decode of the receiving states.
  always_comb begin
    rx_ready = (state == HDR0) || (state == HDR1) || (state == LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == CHK) rx_ready = 1'b1;
`endif
  end

  // Session control FSM with registered write strobe, done pulse and error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      widx     <= 16'd0;
      mem_addr <= '0;
      mem_data <= 32'd0;
      mem_wren <= 1'b0;
      done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      error    <= 1'b0;
`endif
    end else begin
      mem_wren <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR0;
            byte_cnt <= 2'd0;
            widx     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error    <= 1'b0;
`endif
          end
        end
        HDR0: begin
          if (rx_fire) state <= HDR1;
        end
        HDR1: begin
          if (rx_fire) begin
            if ({rx_data, count[7:0]} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (rx_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= WRITE;
              mem_wren <= 1'b1;
              mem_addr <= ADDR_W'(widx);
              mem_data <= {rx_data, word_lo};
            end
          end
        end
        WRITE: begin
          widx <= widx_nxt;
          if (widx_nxt == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHK;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            state <= LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (rx_fire) begin
            if (rx_data != csum) error <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Header capture, payload byte assembly and checksum accumulation (datapath, no reset).
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= 8'd0;
`endif
    end else if (rx_fire) begin
      case (state)
        HDR0: count[7:0]  <= rx_data;
        HDR1: count[15:8] <= rx_data;
        LOAD: begin
          case (byte_cnt)
            2'd0:    word_lo[7:0]   <= rx_data;
            2'd1:    word_lo[15:8]  <= rx_data;
            2'd2:    word_lo[23:16] <= rx_data;
            default: word_lo        <= word_lo;
          endcase
        end
        default: count <= count;
      endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state != CHK) csum <= csum + rx_data;
`endif
    end
  end

`ifndef IMEM_LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized load sessions for imem_loader,
// checked against a byte-list model of the expected memory writes.
// A narrow address width is used so that address wrap-around is reachable.
module tb_imem_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          mem_wren;
  logic          cpu_stall;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .cpu_stall(cpu_stall),
    .done     (done),
    .error    (error)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  pl[$];      // payload bytes of the next session
  logic [7:0]  tx_q[$];    // full byte stream of the next session
  logic [63:0] exp_wr[$];  // expected {addr, data} writes
  logic [63:0] wr_q[$];    // observed {addr, data} writes
  logic [7:0]  exp_csum;
  int          done_cnt = 0;
  int          wren_run = 0;
  int          wren_max = 0;
  bit          gap_phase = 1'b0;

  // Observe write strobes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (mem_wren) begin
      wr_q.push_back({32'(mem_addr), mem_data});
      wren_run = wren_run + 1;
      if (wren_run > wren_max) wren_max = wren_run;
    end else begin
      wren_run = 0;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: stream = count header, payload, and the list of writes it implies.
  task automatic make_session(input int cnt);
    int s;
    tx_q = {};
    exp_wr = {};
    tx_q.push_back(8'(cnt));
    tx_q.push_back(8'(cnt >> 8));
    foreach (pl[i]) tx_q.push_back(pl[i]);
    for (int w = 0; w < cnt; w++)
      exp_wr.push_back({32'(w % (1 << AW)), pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]});
    s = 0;
    foreach (tx_q[i]) s = s + int'(tx_q[i]);
    exp_csum = 8'(s);
  endtask

  task automatic rand_payload(input int cnt);
    pl = {};
    for (int i = 0; i < 4 * cnt; i++) pl.push_back(8'($urandom));
  endtask

  // Offer one byte until it is taken; gaps drops rx_valid every other cycle.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse);
    bit sent = 1'b0;
    bit rdy;
    bit v;
    int n = 0;
    while (!sent && n < 64) begin
      @(negedge clk);
      n++;
      start     = pulse && (n == 1);
      gap_phase = ~gap_phase;
      v         = !(gaps && gap_phase);
      rx_valid  = v;
      rx_data   = v ? b : 8'($urandom);
      rdy       = rx_ready;
      @(posedge clk);
      sent = v && rdy;
    end
    if (!sent) check("tx_timeout", 64'(sent), 64'd1);
  endtask

  task automatic run_session(input bit gaps, input int glitch_idx, input bit csum_bad, input string tag);
    int  d0;
    int  n;
    bit  exp_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(csum_bad ? exp_csum + 8'd1 : exp_csum);
    exp_err = csum_bad;
`else
    exp_err = 1'b0;
`endif
    wr_q = {};
    wren_max = 0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_stall_on"}, 64'(cpu_stall), 64'd1);
    check({tag, "_err_clr"}, 64'(error), 64'd0);
    foreach (tx_q[k]) send_byte(tx_q[k], gaps, k == glitch_idx);
    n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(negedge clk);
      rx_valid = 1'b0;
      start = 1'b0;
      #1;
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    @(negedge clk);
    #1;
    check({tag, "_stall_off"}, 64'(cpu_stall), 64'd0);
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    foreach (exp_wr[k])
      check({tag, "_wr"}, (k < wr_q.size()) ? wr_q[k] : {64{1'bx}}, exp_wr[k]);
    if (exp_wr.size() > 0) check({tag, "_wren_1cyc"}, 64'(wren_max), 64'd1);
    check({tag, "_error"}, 64'(error), 64'(exp_err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_wren", 64'(mem_wren), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    check("rst_stall", 64'(cpu_stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    resetn = 1'b1;

    // Two-word program with rx_valid held high.
    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h10, 8'h00};
    make_session(2);
    run_session(1'b0, -1, 1'b0, "two_word");
    check("two_word_w0", (wr_q.size() > 0) ? wr_q[0] : {64{1'bx}}, {32'd0, 32'h0000_0013});
    check("two_word_w1", (wr_q.size() > 1) ? wr_q[1] : {64{1'bx}}, {32'd1, 32'h0010_0193});

    // Empty program.
    pl = {};
    make_session(0);
    run_session(1'b0, -1, 1'b0, "empty");

    // One word with rx_valid toggling every other cycle.
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    make_session(1);
    gap_phase = 1'b0;
    run_session(1'b1, -1, 1'b0, "gappy");
    check("gappy_w0", (wr_q.size() > 0) ? wr_q[0] : {64{1'bx}}, {32'd0, 32'h0000_0013});

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good and bad trailing checksum; error must stay set afterwards.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    make_session(1);
    run_session(1'b0, -1, 1'b0, "csum_ok");
    make_session(1);
    run_session(1'b0, -1, 1'b1, "csum_bad");
    repeat (5) @(negedge clk);
    #1;
    check("csum_sticky", 64'(error), 64'd1);
`endif

    // Reset after two of four payload bytes.
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    make_session(1);
    wr_q = {};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(tx_q[k], 1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("abort_rx_ready", 64'(rx_ready), 64'd0);
    check("abort_stall", 64'(cpu_stall), 64'd0);
    check("abort_addr", 64'(mem_addr), 64'd0);
    check("abort_data", 64'(mem_data), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    #1;
    check("abort_nwr", 64'(wr_q.size()), 64'd0);
    resetn = 1'b1;
    rand_payload(2);
    make_session(2);
    run_session(1'b0, -1, 1'b0, "after_abort");

    // Start pulsed in the middle of a payload word is ignored.
    rand_payload(2);
    make_session(2);
    run_session(1'b0, 4, 1'b0, "start_glitch");

    // More words than the address space: addresses wrap.
    rand_payload(6);
    make_session(6);
    run_session(1'($urandom_range(0, 1)), -1, 1'b0, "wrap");

    // Randomized sessions.
    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(0, 5);
      rand_payload(c);
      make_session(c);
      run_session(1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 16, instruction-memory word-address width.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  single-cycle request to begin a load session.
REQ-005 Port: rx_valid  input  1  byte-stream source has a byte.
REQ-006 Port: rx_data  input  8  byte from the source.
REQ-007 Port: rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 Port: mem_addr  output  ADDR_W  instruction-memory write address (word index).
REQ-009 Port: mem_data  output  32  instruction-memory write data.
REQ-010 Port: mem_wren  output  1  instruction-memory write enable.
REQ-011 Port: cpu_stall  output  1  high while a session is active; holds CPU fetch and decode.
REQ-012 Port: done  output  1  single-cycle pulse at session end.
REQ-013 Port: error  output  1  sticky checksum-mismatch flag.

Function
REQ-014 States: IDLE, HDR0, HDR1, LOAD, WRITE, CHK, DONE; the block SHALL be in exactly one at a time.
REQ-015 A byte SHALL transfer only on a rising edge where rx_valid=1 and rx_ready=1.
REQ-016 rx_ready SHALL be 1 in HDR0, HDR1, LOAD and CHK, and 0 in IDLE, WRITE and DONE.
REQ-017 In IDLE, start=1 SHALL clear error, clear the byte counter, word index and checksum, and move to HDR0; start SHALL be ignored in every other state.
REQ-018 HDR0 and HDR1 SHALL capture word count bits [7:0] and [15:8] respectively, one byte each.
REQ-019 After HDR1, count=0 SHALL go to CHK if checksum is compiled in, else to DONE; count>0 SHALL go to LOAD.
REQ-020 LOAD SHALL assemble 4 bytes little-endian (first byte -> bits [7:0], fourth -> bits [31:24]) and move to WRITE after the fourth byte.
REQ-021 WRITE SHALL last exactly one cycle with mem_wren=1, mem_addr=word index, mem_data=assembled word.
REQ-022 After WRITE, the word index SHALL increment; if the new index equals count, the next state SHALL be CHK (checksum compiled in) or DONE, else LOAD.
REQ-023 Word index SHALL be truncated to ADDR_W bits; counts above 2^ADDR_W SHALL wrap addresses modulo 2^ADDR_W.
REQ-024 mem_wren SHALL be 0 in every state except WRITE; mem_addr and mem_data SHALL hold their last values outside WRITE.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 cpu_stall SHALL be 1 in every state except IDLE, combinationally from the state register.
REQ-027 rx_valid=0 in a receiving state SHALL hold the state and all partial data indefinitely.

Reset
REQ-028 resetn=0 SHALL force IDLE immediately and drive rx_ready=0, mem_wren=0, mem_addr=0, mem_data=0, cpu_stall=0, done=0, error=0.
REQ-029 Reset mid-session SHALL abort without further writes; words already written SHALL remain in memory.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, an 8-bit checksum SHALL accumulate (sum mod 256) over both header bytes and all payload bytes.
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, CHK SHALL accept one byte; a mismatch with the checksum SHALL set error=1; DONE SHALL follow in either case.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, state CHK and the accumulator SHALL not exist and error SHALL be constant 0.

Verification
REQ-033 Start; bytes 02 00, 13 00 00 00, 93 01 10 00 with rx_valid held high -> writes addr0=0x00000013 then addr1=0x00100193; each mem_wren high 1 cycle; done pulses once; cpu_stall is 1 from the cycle after start until DONE ends.
REQ-034 Start; bytes 00 00, then checksum 00 if enabled -> no mem_wren; done pulses; error=0.
REQ-035 One-word load with rx_valid toggling every other cycle -> identical write to REQ-033 word 0; no bytes lost or duplicated.
REQ-036 With checksum enabled: bytes 01 00 01 02 03 04, then checksum 0B -> error=0; the same session with checksum 0C -> error=1, done pulses, error stays 1 until next start.
REQ-037 Assert resetn=0 after 2 of 4 payload bytes -> IDLE, all outputs at reset values, no mem_wren; a new session then loads correctly.
REQ-038 Pulse start during LOAD -> ignored; session completes unchanged.
